uart_tx_arbiter: RTL

//  Round-robin arbiter sharing one uart_tx instance between N_REQ byte producers.

---
 rtl/uart_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 19 +
 rtl/uart_tx_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and sizing helpers for the uart tx arbiter
package uart_pkg;
  typedef enum logic [1:0] {ARB, LAUNCH, WAIT, GAP} uart_arb_state_t;
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
  function automatic int cnt_width(input int timeout, input int gap_len);
    return $clog2((timeout > gap_len ? timeout : gap_len) + 1);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin select starting at ptr
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int W = $clog2(N);
  always_comb begin
    idx = '0;
    any = |valid;
    for (int k = N - 1; k >= 0; k--)
      if (valid[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
    onehot = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx between N_REQ byte producers
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int GAP_BITS  = 1,
  parameter int TIMEOUT   = 12 * calc_div(CLK_FREQ, BAUD_RATE)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_en,
  output logic [7:0]               tx_data,
  input  logic                     tx_done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     timeout_err
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int GL = GAP_BITS * DIV;
  localparam int CW = cnt_width(TIMEOUT, GL);
  localparam int IW = $clog2(N_REQ);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GL_LAST = CW'(GL > 0 ? GL - 1 : 0);
  localparam uart_arb_state_t POST = GL > 0 ? GAP : ARB;
  uart_arb_state_t state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0] win_idx;
  logic any;
  rr_arbiter #(.N(N_REQ)) u_rr (
    .valid(req_valid),
    .ptr(ptr),
    .onehot(win_oh),
    .idx(win_idx),
    .any(any)
  );
  assign req_ready = (state == ARB) ? win_oh : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      ptr         <= '0;
      cnt         <= '0;
      tx_en       <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_en       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ARB:
          if (any) begin
            tx_data  <= req_data[8*win_idx +: 8];
            grant_id <= win_idx;
            ptr      <= IW'((int'(win_idx) + 1) % N_REQ);
            tx_en    <= 1'b1;
            busy     <= 1'b1;
            state    <= LAUNCH;
          end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT:
          if (tx_done || cnt == TO_LAST) begin
            timeout_err <= !tx_done;
            cnt         <= '0;
            busy        <= (POST != ARB);
            state       <= POST;
          end else cnt <= cnt + 1'b1;
        GAP:
          if (cnt == GL_LAST) begin
            busy  <= 1'b0;
            state <= ARB;
          end else cnt <= cnt + 1'b1;
        default: state <= ARB;
      endcase
    end
  end
endmodule
